hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Hazard and run-control unit for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
//  Generates forwarding selects for EX operands and ID branch compares, stall/flush controls for IF, ID and EX,
//  busy tracking for the multi-cycle MDU (mult/div), and a RUN/HALT/STEP FSM for board single-stepping.
//  Sits beside the pipeline top: it reads stage register/control fields and drives pipe-register enables and clears.
// PARAMETERS
//  MDU_LAT  32  cycles an MDU op occupies after issue in EX (>=1)
//  CNT_W    6   MDU counter width; must hold MDU_LAT-1
// PORTS
//  clk        in   1  clock, all state updates on rising edge
//  rst        in   1  synchronous reset, active-high
//  rsD,rtD    in   5  source register fields in ID
//  BranchD    in   1  ID holds a branch (beq/bne)
//  PCSrcD     in   1  branch resolved taken in ID
//  jumpD      in   1  ID holds a jump
//  mdu_useD   in   1  ID instruction reads HI/LO or starts an MDU op
//  rsE,rtE    in   5  source register fields in EX
//  r3_addrE   in   5  EX destination; RegWriteE, MemtoRegE in 1 each
//  mdu_startE in   1  EX issues an MDU op this cycle
//  r3_addrM   in   5  MEM destination; RegWriteM, MemtoRegM in 1 each
//  r3_addrW   in   5  WB destination; RegWriteW in 1
//  halt_req   in   1  request HALT; step_req in 1 one-instruction step; run_req in 1 resume
//  fwdAE,fwdBE out 2  EX operand select: 00 regfile, 01 WB result, 10 MEM alu_out
//  fwdAD,fwdBD out 1  ID compare operand from MEM alu_out
//  stallF     out  1  hold PC; stallD out 1 hold IF/ID register
//  flushD     out  1  clear IF/ID; flushE out 1 clear ID/EX (bubble)
//  mdu_busy   out  1  MDU counter non-zero
//  run_state  out  2  00 RUN, 01 HALT, 10 STEP
// BEHAVIOUR
//  Reset (rst=1 at edge): run_state<=RUN, MDU counter<=0. While rst is high, outputs are stallF=stallD=0,
//   flushD=flushE=1, fwd*=0, mdu_busy=0.
//  Forwarding (combinational, zero latency); register 0 never forwards:
//   fwdAE=10 if RegWriteM & r3_addrM!=0 & r3_addrM==rsE; else 01 if RegWriteW & r3_addrW!=0 & ==rsE; else 00.
//   fwdBE: same rule using rtE. fwdAD/fwdBD=1 if RegWriteM & r3_addrM!=0 & r3_addrM==rsD/rtD. MEM has priority over WB.
//  lwstall = MemtoRegE & r3_addrE!=0 & (r3_addrE==rsD | r3_addrE==rtD).
//  brstall = BranchD & ((RegWriteE & r3_addrE!=0 & r3_addrE in {rsD,rtD})
//            | (MemtoRegM & r3_addrM!=0 & r3_addrM in {rsD,rtD})).
//  mdustall = mdu_useD & (mdu_busy | mdu_startE).
//  MDU counter: mdu_startE & counter==0 -> load MDU_LAT-1; else if non-zero, decrement; saturates at 0.
//   mdu_startE while busy cannot occur (mdustall guarantees it); if asserted anyway, it is ignored.
//  FSM: RUN -halt_req-> HALT; HALT -run_req-> RUN, else -step_req-> STEP; STEP -> HALT (always, 1 cycle).
//   If run_req and step_req arrive together in HALT, run_req wins. halt_req in STEP has no effect (STEP is one cycle).
//  freeze = (run_state==HALT). STEP behaves as RUN for exactly one cycle.
//  stallF = stallD = lwstall | brstall | mdustall | freeze.
//  flushE = stallD (bubble into EX; downstream stages drain during HALT).
//  flushD = (PCSrcD | jumpD) & ~stallD. A redirect under stall is deferred until the stall clears.
//  A taken branch coincident with halt_req: the redirect is applied in that cycle, and HALT starts on the next cycle.
//  Reset mid-MDU op or mid-HALT: counter is cleared and the FSM returns to RUN.
// STRUCTURE
//  hazard_pkg: FWD_RF/FWD_WB/FWD_MEM encodings, RUN/HALT/STEP state encodings, REG_AW=5.
//  Sub-module mdu_busy_cnt (load/decrement counter, busy flag). All other logic stays in hazard_ctrl.
// TESTING
//  lw $2 in EX (MemtoRegE=1,r3_addrE=2), rsD=2 -> stallF=stallD=flushE=1 for 1 cycle; next cycle fwdAE=01.
//  add in MEM writes $5 and WB writes $5, rsE=5 -> fwdAE=10; r3_addrM=0 with rsE=0 -> fwdAE=00.
//  beq with rsD=3, RegWriteE & r3_addrE=3 -> brstall 1 cycle, then fwdAD=1; PCSrcD=1 -> flushD=1.
//  MDU_LAT=4: mdu_startE, then mdu_useD held -> mdu_busy high 3 cycles, stallD high during those cycles, then released.
//  halt_req -> HALT, stallF=1 held; step_req -> exactly one cycle with stallF=0; run_req+step_req -> RUN.
//  rst asserted mid-MDU op while in HALT -> next cycle run_state=00, mdu_busy=0, flushD=flushE=1 while rst=1.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard and run-control unit.
// Forwarding selects, run-state codes, register address width, match helper.
package hazard_pkg;

    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        HALT = 2'b01,
        STEP = 2'b10
    } run_state_t;

    // A writing stage matches a source only when it really writes a
    // non-zero register; $0 is hardwired and never forwards or stalls.
    function automatic logic reg_hit(
        input logic      we,
        input reg_addr_t dst,
        input reg_addr_t src
    );
        return we && (dst != '0) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard/run-control unit.
// master: pipeline side (drives stage fields, receives controls); slave: hazard unit.
interface hazard_ctrl_if;

    // ID stage
    logic [hazard_pkg::REG_AW-1:0] rsD;
    logic [hazard_pkg::REG_AW-1:0] rtD;
    logic                          BranchD;
    logic                          PCSrcD;
    logic                          jumpD;
    logic                          mdu_useD;
    // EX stage
    logic [hazard_pkg::REG_AW-1:0] rsE;
    logic [hazard_pkg::REG_AW-1:0] rtE;
    logic [hazard_pkg::REG_AW-1:0] r3_addrE;
    logic                          RegWriteE;
    logic                          MemtoRegE;
    logic                          mdu_startE;
    // MEM stage
    logic [hazard_pkg::REG_AW-1:0] r3_addrM;
    logic                          RegWriteM;
    logic                          MemtoRegM;
    // WB stage
    logic [hazard_pkg::REG_AW-1:0] r3_addrW;
    logic                          RegWriteW;
    // board run control
    logic                          halt_req;
    logic                          step_req;
    logic                          run_req;
    // controls back to the pipeline
    logic [1:0]                    fwdAE;
    logic [1:0]                    fwdBE;
    logic                          fwdAD;
    logic                          fwdBD;
    logic                          stallF;
    logic                          stallD;
    logic                          flushD;
    logic                          flushE;
    logic                          mdu_busy;
    logic [1:0]                    run_state;

    modport master (
        output rsD, rtD, BranchD, PCSrcD, jumpD, mdu_useD,
        output rsE, rtE, r3_addrE, RegWriteE, MemtoRegE, mdu_startE,
        output r3_addrM, RegWriteM, MemtoRegM,
        output r3_addrW, RegWriteW,
        output halt_req, step_req, run_req,
        input  fwdAE, fwdBE, fwdAD, fwdBD,
        input  stallF, stallD, flushD, flushE,
        input  mdu_busy, run_state
    );

    modport slave (
        input  rsD, rtD, BranchD, PCSrcD, jumpD, mdu_useD,
        input  rsE, rtE, r3_addrE, RegWriteE, MemtoRegE, mdu_startE,
        input  r3_addrM, RegWriteM, MemtoRegM,
        input  r3_addrW, RegWriteW,
        input  halt_req, step_req, run_req,
        output fwdAE, fwdBE, fwdAD, fwdBD,
        output stallF, stallD, flushD, flushE,
        output mdu_busy, run_state
    );

endinterface

// File: rtl/hazard_ctrl_mdu_busy_cnt.sv
// Multi-cycle MDU occupancy counter: loads MDU_LAT-1 on an issue, counts down to 0.
// Ports: clk, rst (sync, high), start (issue in EX), busy (counter non-zero).
module mdu_busy_cnt #(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy
);

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(MDU_LAT - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // An issue while already counting is ignored; the ID-side stall
    // keeps that from happening in a well-formed pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (start && (cnt == '0)) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and run-control unit for the 5-stage pipeline: forwarding, stalls, flushes,
// MDU busy tracking, RUN/HALT/STEP FSM. Ports: clk, rst (sync, high), hz (slave bundle).
module hazard_ctrl #(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    import hazard_pkg::*;

    run_state_t state_q;
    run_state_t state_d;

    logic cnt_busy;
    logic lwstall;
    logic brstall;
    logic mdustall;
    logic freeze;
    logic stall;
    logic redirect;

    logic memA_E, wbA_E, memB_E, wbB_E;
    logic exA_D, exB_D, mlA_D, mlB_D;

    mdu_busy_cnt #(
        .MDU_LAT (MDU_LAT),
        .CNT_W   (CNT_W)
    ) u_mdu_cnt (
        .clk   (clk),
        .rst   (rst),
        .start (hz.mdu_startE),
        .busy  (cnt_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // STEP lasts exactly one cycle; run_req beats step_req in HALT.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (hz.halt_req) state_d = HALT;
            HALT: begin
                if (hz.run_req)       state_d = RUN;
                else if (hz.step_req) state_d = STEP;
            end
            STEP:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    assign memA_E = reg_hit(hz.RegWriteM, hz.r3_addrM, hz.rsE);
    assign wbA_E  = reg_hit(hz.RegWriteW, hz.r3_addrW, hz.rsE);
    assign memB_E = reg_hit(hz.RegWriteM, hz.r3_addrM, hz.rtE);
    assign wbB_E  = reg_hit(hz.RegWriteW, hz.r3_addrW, hz.rtE);

    // Branch operands are compared in ID, so an EX producer or a MEM
    // load cannot be forwarded in time and must stall the branch.
    assign exA_D = reg_hit(hz.RegWriteE, hz.r3_addrE, hz.rsD);
    assign exB_D = reg_hit(hz.RegWriteE, hz.r3_addrE, hz.rtD);
    assign mlA_D = reg_hit(hz.MemtoRegM, hz.r3_addrM, hz.rsD);
    assign mlB_D = reg_hit(hz.MemtoRegM, hz.r3_addrM, hz.rtD);

    assign lwstall = reg_hit(hz.MemtoRegE, hz.r3_addrE, hz.rsD)
                   | reg_hit(hz.MemtoRegE, hz.r3_addrE, hz.rtD);
    assign brstall = hz.BranchD & (exA_D | exB_D | mlA_D | mlB_D);

    // An issue in EX counts as busy for a dependent op already in ID.
    assign mdustall = hz.mdu_useD & (cnt_busy | hz.mdu_startE);
    assign freeze   = (state_q == HALT);
    assign stall    = lwstall | brstall | mdustall | freeze;
    assign redirect = hz.PCSrcD | hz.jumpD;

    always_comb begin
        hz.fwdAE    = FWD_RF;
        hz.fwdBE    = FWD_RF;
        hz.fwdAD    = 1'b0;
        hz.fwdBD    = 1'b0;
        hz.stallF   = 1'b0;
        hz.stallD   = 1'b0;
        hz.flushD   = 1'b1;
        hz.flushE   = 1'b1;
        hz.mdu_busy = 1'b0;
        if (!rst) begin
            if (memA_E)     hz.fwdAE = FWD_MEM;
            else if (wbA_E) hz.fwdAE = FWD_WB;
            if (memB_E)     hz.fwdBE = FWD_MEM;
            else if (wbB_E) hz.fwdBE = FWD_WB;
            hz.fwdAD    = reg_hit(hz.RegWriteM, hz.r3_addrM, hz.rsD);
            hz.fwdBD    = reg_hit(hz.RegWriteM, hz.r3_addrM, hz.rtD);
            hz.stallF   = stall;
            hz.stallD   = stall;
            hz.flushE   = stall;
            // A redirect under stall waits until the stall clears.
            hz.flushD   = redirect & ~stall;
            hz.mdu_busy = cnt_busy;
        end
    end

    assign hz.run_state = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random stimulus
// against a cycle-indexed behavioural model.
module tb_hazard_ctrl;

    localparam int LAT = 4;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    hazard_ctrl_if bus ();

    hazard_ctrl #(
        .MDU_LAT (LAT),
        .CNT_W   (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: cycle index, last cycle the MDU is busy, run mode.
    int cyc      = 0;
    int busy_end = -1;
    int mode     = 0;
    bit seen_rst = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at cycle %0d",
                     name, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            seen_rst = 1;
            mode     = 0;
            busy_end = -1;
        end else begin
            if (bus.mdu_startE && !(cyc <= busy_end))
                busy_end = cyc + LAT - 1;
            case (mode)
                0: if (bus.halt_req) mode = 1;
                1: begin
                    if (bus.run_req) mode = 0;
                    else if (bus.step_req) mode = 2;
                end
                default: mode = 1;
            endcase
        end
        cyc++;
    end

    function automatic bit wr(input bit we, input int dst, input int src);
        return we && dst != 0 && dst == src;
    endfunction

    function automatic int fwd_e(input int src);
        if (wr(bus.RegWriteM, int'(bus.r3_addrM), src)) return 2;
        if (wr(bus.RegWriteW, int'(bus.r3_addrW), src)) return 1;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (seen_rst) begin
            int  rsd, rtd, ae, am;
            bit  busy, lw, br, md, st;
            int  e_ae, e_be, e_ad, e_bd, e_st, e_fd, e_fe, e_mb;
            rsd  = int'(bus.rsD);
            rtd  = int'(bus.rtD);
            ae   = int'(bus.r3_addrE);
            am   = int'(bus.r3_addrM);
            busy = (cyc <= busy_end);
            lw   = wr(bus.MemtoRegE, ae, rsd) || wr(bus.MemtoRegE, ae, rtd);
            br   = bus.BranchD &&
                   (wr(bus.RegWriteE, ae, rsd) || wr(bus.RegWriteE, ae, rtd) ||
                    wr(bus.MemtoRegM, am, rsd) || wr(bus.MemtoRegM, am, rtd));
            md   = bus.mdu_useD && (busy || bus.mdu_startE);
            st   = lw || br || md || (mode == 1);
            if (rst) begin
                e_ae = 0; e_be = 0; e_ad = 0; e_bd = 0;
                e_st = 0; e_fd = 1; e_fe = 1; e_mb = 0;
            end else begin
                e_ae = fwd_e(int'(bus.rsE));
                e_be = fwd_e(int'(bus.rtE));
                e_ad = int'(wr(bus.RegWriteM, am, rsd));
                e_bd = int'(wr(bus.RegWriteM, am, rtd));
                e_st = int'(st);
                e_fd = int'((bus.PCSrcD || bus.jumpD) && !st);
                e_fe = int'(st);
                e_mb = int'(busy);
            end
            chk("fwdAE", int'(bus.fwdAE), e_ae);
            chk("fwdBE", int'(bus.fwdBE), e_be);
            chk("fwdAD", int'(bus.fwdAD), e_ad);
            chk("fwdBD", int'(bus.fwdBD), e_bd);
            chk("stallF", int'(bus.stallF), e_st);
            chk("stallD", int'(bus.stallD), e_st);
            chk("flushD", int'(bus.flushD), e_fd);
            chk("flushE", int'(bus.flushE), e_fe);
            chk("mdu_busy", int'(bus.mdu_busy), e_mb);
            chk("run_state", int'(bus.run_state), mode);
        end
    end

    task automatic clr();
        bus.rsD = '0; bus.rtD = '0; bus.BranchD = 0; bus.PCSrcD = 0;
        bus.jumpD = 0; bus.mdu_useD = 0;
        bus.rsE = '0; bus.rtE = '0; bus.r3_addrE = '0;
        bus.RegWriteE = 0; bus.MemtoRegE = 0; bus.mdu_startE = 0;
        bus.r3_addrM = '0; bus.RegWriteM = 0; bus.MemtoRegM = 0;
        bus.r3_addrW = '0; bus.RegWriteW = 0;
        bus.halt_req = 0; bus.step_req = 0; bus.run_req = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        clr();
        tick();
        tick();
        at_neg();
        chk("rst_stallF", int'(bus.stallF), 0);
        chk("rst_flushD", int'(bus.flushD), 1);
        chk("rst_flushE", int'(bus.flushE), 1);
        chk("rst_state", int'(bus.run_state), 0);
        chk("rst_busy", int'(bus.mdu_busy), 0);
        tick();
        rst = 1'b0;
        at_neg();
        chk("idle_flushD", int'(bus.flushD), 0);

        // load-use stall, then WB forwarding
        tick();
        bus.MemtoRegE = 1; bus.RegWriteE = 1; bus.r3_addrE = 5'd2;
        bus.rsD = 5'd2;
        at_neg();
        chk("lw_stallF", int'(bus.stallF), 1);
        chk("lw_flushE", int'(bus.flushE), 1);
        tick();
        clr();
        bus.RegWriteW = 1; bus.r3_addrW = 5'd2; bus.rsE = 5'd2;
        at_neg();
        chk("lw_fwdAE", int'(bus.fwdAE), 1);
        chk("lw_release", int'(bus.stallF), 0);

        // MEM beats WB; $0 never forwards
        tick();
        clr();
        bus.RegWriteM = 1; bus.r3_addrM = 5'd5;
        bus.RegWriteW = 1; bus.r3_addrW = 5'd5;
        bus.rsE = 5'd5; bus.rtE = 5'd5;
        at_neg();
        chk("mem_fwdAE", int'(bus.fwdAE), 2);
        chk("mem_fwdBE", int'(bus.fwdBE), 2);
        tick();
        clr();
        bus.RegWriteM = 1; bus.r3_addrM = 5'd0; bus.rsE = 5'd0;
        at_neg();
        chk("r0_fwdAE", int'(bus.fwdAE), 0);

        // branch stall defers redirect, then ID forwarding + flush
        tick();
        clr();
        bus.BranchD = 1; bus.PCSrcD = 1; bus.rsD = 5'd3;
        bus.RegWriteE = 1; bus.r3_addrE = 5'd3;
        at_neg();
        chk("br_stallD", int'(bus.stallD), 1);
        chk("br_flushD_held", int'(bus.flushD), 0);
        tick();
        clr();
        bus.BranchD = 1; bus.PCSrcD = 1; bus.rsD = 5'd3;
        bus.RegWriteM = 1; bus.r3_addrM = 5'd3;
        at_neg();
        chk("br_fwdAD", int'(bus.fwdAD), 1);
        chk("br_stall_off", int'(bus.stallD), 0);
        chk("br_flushD", int'(bus.flushD), 1);

        // MDU issue with a dependent op held in ID
        tick();
        clr();
        bus.mdu_startE = 1; bus.mdu_useD = 1;
        at_neg();
        chk("mdu_issue_stall", int'(bus.stallD), 1);
        tick();
        bus.mdu_startE = 0;
        for (int i = 0; i < LAT - 1; i++) begin
            at_neg();
            chk("mdu_busy_on", int'(bus.mdu_busy), 1);
            chk("mdu_stallD", int'(bus.stallD), 1);
            tick();
        end
        at_neg();
        chk("mdu_busy_off", int'(bus.mdu_busy), 0);
        chk("mdu_release", int'(bus.stallD), 0);

        // HALT, single STEP, run+step resumes
        tick();
        clr();
        bus.halt_req = 1;
        at_neg();
        chk("halt_req_cycle", int'(bus.stallF), 0);
        tick();
        bus.halt_req = 0;
        at_neg();
        chk("halt_state", int'(bus.run_state), 1);
        chk("halt_stallF", int'(bus.stallF), 1);
        tick();
        bus.step_req = 1;
        at_neg();
        chk("halt_hold", int'(bus.stallF), 1);
        tick();
        bus.step_req = 0;
        at_neg();
        chk("step_state", int'(bus.run_state), 2);
        chk("step_stallF", int'(bus.stallF), 0);
        tick();
        at_neg();
        chk("step_back", int'(bus.run_state), 1);
        tick();
        bus.run_req = 1; bus.step_req = 1;
        tick();
        clr();
        at_neg();
        chk("run_wins", int'(bus.run_state), 0);

        // reset during an MDU op while halted
        tick();
        bus.mdu_startE = 1; bus.halt_req = 1;
        tick();
        clr();
        at_neg();
        chk("pre_rst_busy", int'(bus.mdu_busy), 1);
        chk("pre_rst_halt", int'(bus.run_state), 1);
        tick();
        rst = 1'b1;
        at_neg();
        chk("mid_rst_flushD", int'(bus.flushD), 1);
        chk("mid_rst_flushE", int'(bus.flushE), 1);
        tick();
        rst = 1'b0;
        at_neg();
        chk("post_rst_state", int'(bus.run_state), 0);
        chk("post_rst_busy", int'(bus.mdu_busy), 0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst           = ($urandom_range(0, 59) == 0);
            bus.rsD       = 5'($urandom_range(0, 3));
            bus.rtD       = 5'($urandom_range(0, 3));
            bus.BranchD   = ($urandom_range(0, 3) == 0);
            bus.PCSrcD    = ($urandom_range(0, 3) == 0);
            bus.jumpD     = ($urandom_range(0, 7) == 0);
            bus.mdu_useD  = ($urandom_range(0, 3) == 0);
            bus.rsE       = 5'($urandom_range(0, 3));
            bus.rtE       = 5'($urandom_range(0, 3));
            bus.r3_addrE  = 5'($urandom_range(0, 3));
            bus.RegWriteE = 1'($urandom_range(0, 1));
            bus.MemtoRegE = ($urandom_range(0, 3) == 0);
            bus.mdu_startE = ($urandom_range(0, 9) == 0);
            bus.r3_addrM  = 5'($urandom_range(0, 3));
            bus.RegWriteM = 1'($urandom_range(0, 1));
            bus.MemtoRegM = ($urandom_range(0, 3) == 0);
            bus.r3_addrW  = 5'($urandom_range(0, 3));
            bus.RegWriteW = 1'($urandom_range(0, 1));
            bus.halt_req  = ($urandom_range(0, 11) == 0);
            bus.step_req  = ($urandom_range(0, 4) == 0);
            bus.run_req   = ($urandom_range(0, 6) == 0);
        end
        tick();
        at_neg();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
